// File: rtl/sr1_pkg.sv
// Shared constants for the sr1 shift-right-by-one slice.
package sr1_pkg;

    // Default datapath width used by the top level.
    localparam int unsigned SR1_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/sr1_bit_mux.sv
// One bit of the sr1 datapath: a 2:1 mux choosing the bit itself (a) or its
// upper neighbour (b).
module sr1_bit_mux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    // sel=1 takes the neighbour bit, which is what makes the word shift right.
    assign y = sel ? b : a;

endmodule

// File: rtl/sr1.sv
// Logical shift-right-by-one with pass-through, plus registered copies of the
// result and of the bit shifted out.
import sr1_pkg::*;

module sr1 #(
    parameter int WIDTH = SR1_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             lsb_q
);

    // Upper neighbour of each bit; a zero is fed into the MSB so the shift is
    // logical and the sign bit is never replicated.
    logic [WIDTH-1:0] upper;

    assign upper = {1'b0, in[WIDTH-1:1]};

    // One mux per bit builds the combinational result.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr1_bit_mux u_mux (
            .a   (in[i]),
            .b   (upper[i]),
            .sel (enable),
            .y   (out[i])
        );
    end

    // Capture the result and the shifted-out bit every cycle; reset clears both.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
            lsb_q <= 1'b0;
        end else begin
            out_q <= out;
            lsb_q <= enable & in[0];
        end
    end

endmodule

// File: tb/tb_sr1.sv
// Self-checking bench for sr1: combinational result checked each cycle,
// registered outputs checked one cycle later through a scoreboard queue.
module tb_sr1;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             l;
    } exp_t;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             enable;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             lsb_q;

    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];

    sr1 #(.WIDTH(WIDTH)) u_dut (
        .clock  (clock),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out),
        .out_q  (out_q),
        .lsb_q  (lsb_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] ref_out(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        r = v;
        if (en) begin
            for (int i = 0; i < WIDTH - 1; i++) r[i] = v[i + 1];
            r[WIDTH-1] = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check out, queue the registered
    // expectation, then compare the registered outputs after the rising edge.
    task automatic cycle(input logic [WIDTH-1:0] in_v, input logic en_v, input logic rst_v);
        exp_t e;
        exp_t got_e;
        logic [WIDTH-1:0] comb;
        @(negedge clock);
        in     = in_v;
        enable = en_v;
        reset  = rst_v;
        #1;
        comb = ref_out(in_v, en_v);
        check("out", out, comb);
        e.q = rst_v ? '0 : comb;
        e.l = rst_v ? 1'b0 : (en_v & in_v[0]);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got_e = sb_q.pop_front();
            check("out_q", out_q, got_e.q);
            check("lsb_q", {31'd0, lsb_q}, {31'd0, got_e.l});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset  = 1'b1;
        in     = '0;
        enable = 1'b0;

        // Reset state, with data present that must be ignored.
        cycle(32'd45, 1'b1, 1'b1);
        cycle(32'hFFFF_FFFF, 1'b1, 1'b1);

        // Directed scenarios, with explicit literal checks of out as well.
        @(negedge clock);
        reset = 1'b0; in = 32'd45; enable = 1'b1; #1;
        check("dir_shift45", out, 32'h0000_0016);
        enable = 1'b0; #1;
        check("dir_pass45", out, 32'd45);
        in = 32'h8000_0000; enable = 1'b1; #1;
        check("dir_msb", out, 32'h4000_0000);
        in = 32'hFFFF_FFFF; #1;
        check("dir_ones", out, 32'h7FFF_FFFF);

        cycle(32'd45, 1'b1, 1'b0);
        cycle(32'd45, 1'b0, 1'b0);
        cycle(32'h8000_0000, 1'b1, 1'b0);
        cycle(32'hFFFF_FFFF, 1'b1, 1'b0);
        cycle(32'd1, 1'b1, 1'b0);
        cycle(32'd1, 1'b0, 1'b0);

        // Load 0x16, then reset with live data: out must keep tracking.
        cycle(32'd45, 1'b1, 1'b0);
        cycle(32'd45, 1'b1, 1'b1);
        check("rst_out_live", out, 32'd22);
        cycle(32'd45, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 1000; n++) begin
            cycle($urandom, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
